// File: rtl/switch_entry_rx.sv
`default_nettype none
// ============================================================================
// switch_entry_rx : switch-strobe nibble entry with debounce, 4-entry FWFT FIFO
// Revision: 1.0
// ============================================================================
module switch_entry_rx #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [9:0] SW,
    input  logic       data_ready,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic [2:0] fifo_count,
    output logic       overflow,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_ARM_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_ARM_LOW  = 2'd3;

    localparam logic [7:0] C_DEB  = 8'(DEBOUNCE_CYCLES);
    localparam logic [2:0] C_FULL = 3'(FIFO_DEPTH);

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-F
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [4:0] r_sync1, r_sync2;
    logic [1:0] r_state, w_state_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic       w_push, w_pop, w_wr, w_full, w_sample;
    logic [3:0] w_data;
    logic [3:0] r_mem [0:3];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;
    logic       r_overflow;
    logic [6:0] r_hex0;
    logic       w_unused_sw;

    assign w_unused_sw = ^SW[4:0];
    assign w_sample    = r_sync2[0];
    assign w_data      = r_sync2[4:1];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_push     = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_sample) begin
                    w_state_nx = S_ARM_HIGH;
                    w_cnt_nx   = 8'd1;
                end
            end
            S_ARM_HIGH: begin
                if (!w_sample) begin
                    w_state_nx = S_LOW;
                    w_cnt_nx   = 8'd0;
                end else if (r_cnt == C_DEB) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = 8'd0;
                    w_push     = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_HIGH: begin
                if (!w_sample) begin
                    w_state_nx = S_ARM_LOW;
                    w_cnt_nx   = 8'd1;
                end
            end
            default: begin
                if (w_sample) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = 8'd0;
                end else if (r_cnt == C_DEB) begin
                    w_state_nx = S_LOW;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
        endcase
    end

    // A push into a full FIFO is still accepted when a pop frees the head slot
    assign w_full = (r_count == C_FULL);
    assign w_pop  = (r_count != 3'd0) && data_ready;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1    <= 5'd0;
            r_sync2    <= 5'd0;
            r_state    <= S_LOW;
            r_cnt      <= 8'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
            r_hex0     <= 7'b1111111;
            for (int i = 0; i < 4; i++) r_mem[i] <= 4'd0;
        end else begin
            r_sync1 <= SW[9:5];
            r_sync2 <= r_sync1;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_push) r_hex0 <= seg7(w_data);
        end
    end

    assign data_out   = r_mem[r_rd_ptr];
    assign data_valid = (r_count != 3'd0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign HEX0       = r_hex0;
    assign HEX1       = seg7({1'b0, r_count});

endmodule
`default_nettype wire

// File: tb/tb_switch_entry_rx.sv
`default_nettype none
// ============================================================================
// tb_switch_entry_rx : directed-vector bench for switch_entry_rx
// Revision: 1.0
// ============================================================================
module tb_switch_entry_rx;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic       data_ready;
    logic [3:0] data_out;
    logic       data_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [6:0] hex0;
    logic [6:0] hex1;

    int n_checks = 0;
    int n_fail   = 0;

    switch_entry_rx #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .SW         (sw),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .HEX0       (hex0),
        .HEX1       (hex1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after a rising edge, reset released
    task automatic do_reset();
        rst_n      = 1'b0;
        sw         = 10'd0;
        data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Strobe high for 8 sampled edges then low long enough to re-arm;
    // data_ready is pulsed only on edge pop_edge (0 = never)
    task automatic enter_nibble(input logic [3:0] nib, input int pop_edge);
        sw[9:6] = nib;
        for (int i = 1; i <= 12; i++) begin
            sw[5]      = (i <= 8);
            data_ready = (i == pop_edge);
            @(posedge clk); #1;
        end
        data_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({data_valid, fifo_count, data_out, overflow} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: valid=%b count=%0d out=%h ovf=%b, want all 0",
                     data_valid, fifo_count, data_out, overflow);
        end
        n_checks++;
        if (hex0 !== 7'b1111111 || hex1 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_hex: hex0=%b hex1=%b, want 1111111 1000000", hex0, hex1);
        end
    endtask

    task automatic test_single_entry();
        int first = 0;
        int vcyc  = 0;
        logic [3:0] got = 4'd0;
        do_reset();
        data_ready = 1'b1;
        sw = {4'h4, 1'b1, 5'd0};
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == 5) sw[5] = 1'b0;
            if (data_valid) begin
                vcyc++;
                if (first == 0) begin
                    first = i;
                    got   = data_out;
                end
            end
        end
        n_checks++;
        if (first != 7) begin
            n_fail++;
            $display("FAIL single_latency: data_valid rose at edge %0d, want 7", first);
        end
        n_checks++;
        if (got !== 4'h4 || vcyc != 1) begin
            n_fail++;
            $display("FAIL single_data: out=%h valid_cycles=%0d, want 4 and 1", got, vcyc);
        end
        n_checks++;
        if (hex0 !== 7'b0011001 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_hex: hex0=%b count=%0d, want 0011001 and 0", hex0, fifo_count);
        end
        data_ready = 1'b0;
    endtask

    task automatic test_glitch();
        int seen = 0;
        do_reset();
        sw = {4'h9, 1'b1, 5'd0};
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == 2) sw[5] = 1'b0;
            if (data_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || hex0 !== 7'b1111111) begin
            n_fail++;
            $display("FAIL glitch: valid_cycles=%0d hex0=%b, want 0 and 1111111", seen, hex0);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp [0:3];
        exp[0] = 4'h5; exp[1] = 4'hC; exp[2] = 4'hF; exp[3] = 4'h0;
        do_reset();
        enter_nibble(4'h4, 0);
        enter_nibble(4'h5, 0);
        enter_nibble(4'hC, 0);
        enter_nibble(4'hF, 0);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || hex1 !== 7'b0011001) begin
            n_fail++;
            $display("FAIL ovf_fill: count=%0d ovf=%b hex1=%b, want 4 0 0011001",
                     fifo_count, overflow, hex1);
        end
        enter_nibble(4'h1, 0);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || hex0 !== 7'b1111001 || data_out !== 4'h4) begin
            n_fail++;
            $display("FAIL ovf_drop: count=%0d ovf=%b hex0=%b out=%h, want 4 1 1111001 4",
                     fifo_count, overflow, hex0, data_out);
        end
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (fifo_count !== 3'(3 - i) || (i < 3 && data_out !== exp[i])) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: count=%0d out=%h, want %0d %h",
                         i, fifo_count, data_out, 3 - i, exp[i]);
            end
        end
        data_ready = 1'b0;
        n_checks++;
        if (data_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: valid=%b ovf=%b, want 0 1", data_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp [0:3];
        exp[0] = 4'h5; exp[1] = 4'hC; exp[2] = 4'hF; exp[3] = 4'h7;
        do_reset();
        enter_nibble(4'h4, 0);
        enter_nibble(4'h5, 0);
        enter_nibble(4'hC, 0);
        enter_nibble(4'hF, 0);
        enter_nibble(4'h7, 7);
        n_checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || data_out !== 4'h5) begin
            n_fail++;
            $display("FAIL fullpp: count=%0d ovf=%b out=%h, want 4 0 5",
                     fifo_count, overflow, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp[i]) begin
                n_fail++;
                $display("FAIL fullpp_order%0d: valid=%b out=%h, want 1 %h",
                         i, data_valid, data_out, exp[i]);
            end
            data_ready = 1'b1;
            @(posedge clk); #1;
            data_ready = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (fifo_count !== 3'd0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_empty: count=%0d valid=%b, want 0 0", fifo_count, data_valid);
        end
    endtask

    task automatic test_reset_mid();
        int first = 0;
        int seen  = 0;
        do_reset();
        enter_nibble(4'h4, 0);
        enter_nibble(4'h5, 0);
        sw = {4'h9, 1'b1, 5'd0};
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_valid, fifo_count, data_out, overflow} !== 9'd0 ||
            hex0 !== 7'b1111111 || hex1 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b count=%0d out=%h ovf=%b hex0=%b hex1=%b",
                     data_valid, fifo_count, data_out, overflow, hex0, hex1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (data_valid && first == 0) first = i;
        end
        n_checks++;
        if (first != 7 || fifo_count !== 3'd1 || data_out !== 4'h9) begin
            n_fail++;
            $display("FAIL rstmid_held: rose at edge %0d count=%0d out=%h, want 7 1 9",
                     first, fifo_count, data_out);
        end
        // Strobe released while in reset: nothing may be pushed afterwards
        rst_n = 1'b0;
        sw[5] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (data_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || hex0 !== 7'b1111111) begin
            n_fail++;
            $display("FAIL rstmid_nopush: valid_cycles=%0d hex0=%b, want 0 1111111", seen, hex0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sw         = 10'd0;
        data_ready = 1'b0;
        test_reset();
        test_single_entry();
        test_glitch();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
